// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial word transmitter with one-deep hold buffer.
// Words leave MSB first on a registered output J, followed by GAP idle-zero bits.
// A word arriving while the shifter is busy waits in the hold register; din_ready
// is the registered "hold empty" flag, so the source stalls only when both are full.
module serial_frame_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             J,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;        // bits still to send, left-aligned
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hf_n;
  logic [CW-1:0]    bit_cnt, bc_n;   // index of the bit currently on J
  logic [3:0]       gap_cnt, gc_n;
  logic             j_n, wd_n;

  logic             hs;
  logic             last_bit;
  logic             last_gap;
  logic             end_frame;
  logic             do_load;
  logic [WIDTH-1:0] ld_word;

  assign hs       = din_valid && din_ready;
  assign last_bit = (state == ST_SHIFT) && (bit_cnt == CW'(WIDTH-1));
  assign last_gap = (state == ST_GAP) && (gap_cnt == 4'(GAP-1));

  // Next-state and next-output decode; J is the registered copy of the bit being sent.
  always_comb begin
    state_n   = state;
    sh_n      = sh;
    hold_n    = hold;
    hf_n      = hold_full;
    bc_n      = bit_cnt;
    gc_n      = gap_cnt;
    j_n       = 1'b0;
    wd_n      = 1'b0;
    end_frame = 1'b0;
    do_load   = 1'b0;
    ld_word   = din;

    case (state)
      ST_IDLE: begin
        // hold is always empty here, so an accepted word goes straight to the shifter
        if (hs) do_load = 1'b1;
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          j_n  = sh[WIDTH-1];
          sh_n = {sh[WIDTH-2:0], 1'b0};
          bc_n = bit_cnt + CW'(1);
          wd_n = (bit_cnt == CW'(WIDTH-2));
        end else if (GAP > 0) begin
          state_n = ST_GAP;
          gc_n    = '0;
        end else begin
          end_frame = 1'b1;
        end
      end
      ST_GAP: begin
        if (!last_gap) gc_n = gap_cnt + 4'd1;
        else           end_frame = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    // Mid-frame arrivals park in the hold register.
    if (hs && (state != ST_IDLE) && !end_frame) begin
      hold_n = din;
      hf_n   = 1'b1;
    end

    // Frame boundary: take the parked word first; a word arriving exactly on the
    // boundary with an empty hold goes straight to the shifter instead of being
    // parked, which would otherwise strand it in IDLE.
    if (end_frame) begin
      if (hold_full) begin
        do_load = 1'b1;
        ld_word = hold;
        hf_n    = 1'b0;
      end else if (hs) begin
        do_load = 1'b1;
      end else begin
        state_n = ST_IDLE;
      end
    end

    if (do_load) begin
      state_n = ST_SHIFT;
      j_n     = ld_word[WIDTH-1];
      sh_n    = {ld_word[WIDTH-2:0], 1'b0};
      bc_n    = '0;
      wd_n    = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      J         <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
      din_ready <= 1'b1;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      hold      <= hold_n;
      hold_full <= hf_n;
      bit_cnt   <= bc_n;
      gap_cnt   <= gc_n;
      J         <= j_n;
      busy      <= (state_n != ST_IDLE);
      word_done <= wd_n;
      din_ready <= !hf_n;
    end
  end

  // The hold buffer can never be occupied while the shifter is idle.
  always_ff @(posedge clk) begin
    if (rst) assert (!(state == ST_IDLE && hold_full));
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial frame transmitter that sits directly upstream of the `10000001` sequence detector and drives its serial input `J`. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word behind the word currently shifting. Each word goes out MSB first, one bit per clock, followed by a programmable run of idle-zero gap bits. The output is registered, so the detector sees a clean, clock-aligned stream.

## Interface
- `WIDTH`, default 8: bits per word; legal values are 2..16.
- `GAP`, default 2: idle `0` bits inserted after every word; legal values are 0..15. When GAP=0, words are sent back to back.
- `clk`  input  1  the only clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `din`  input  WIDTH  word to send. It is sampled only on a handshake.
- `din_valid`  input  1  the source has a word on `din`.
- `din_ready`  output  1  the block can accept a word. It equals "hold buffer empty" and is driven directly from a register.
- `J`  output  1  registered serial output, MSB first. It idles at `0`.
- `busy`  output  1  high while in SHIFT or GAP.
- `word_done`  output  1  one-cycle pulse, high in the cycle `J` carries the word's LSB.

## Operation
- Handshake: a word is accepted on any rising edge where `din_valid && din_ready`. The source may change `din` freely when no handshake occurs.
- Storage:
  - shift register `sh[WIDTH-1:0]`
  - hold register plus a `hold_full` flag
  - bit counter, ceil(log2 WIDTH) bits
  - gap counter, 4 bits
- States:
  - **IDLE**: `J`=0 and `busy`=0.
    - A word accepted with the hold empty loads straight into `sh`; go to SHIFT.
    - `hold_full` is never set while in IDLE.
  - **SHIFT**: `J` = `sh[WIDTH-1]`, and `sh` shifts left by one each cycle.
    - On the last bit (bit counter = WIDTH-1), assert `word_done`.
    - Next state:
      - If GAP>0, go to GAP.
      - Else if `hold_full`, load the hold word into `sh` and stay in SHIFT.
      - Else go to IDLE.
  - **GAP**: `J`=0 for exactly GAP cycles.
    - On the last gap cycle, if `hold_full`, load the hold word into `sh` and go to SHIFT.
    - Otherwise go to IDLE.
- Outside IDLE, an accepted word goes to the hold register and sets `hold_full`.
- Loading `sh` from the hold clears `hold_full` on that same edge. `din_ready` rises on the following cycle.
- A handshake and a hold-to-shifter transfer never coincide, because `din_ready`=0 whenever the hold is full.
- Bits go out exactly as supplied. There is no framing, parity or inversion.

## Timing
- Reset (`rst`=0 at an edge):
  - state becomes IDLE
  - `J`=0, `busy`=0, `word_done`=0
  - `hold_full`=0, so `din_ready`=1 from the cycle after the reset edge
  - counters become 0
- A reset in the middle of a frame aborts it immediately. Both the shifting word and the held word are discarded, and `J` is 0 from the next cycle.
- Latency:
  - A word accepted at edge k in IDLE puts its MSB on `J` in cycle k+1.
  - Its LSB appears in cycle k+WIDTH, with `word_done` high in that cycle.
- Gap: `J`=0 in cycles k+WIDTH+1 .. k+WIDTH+GAP.
- Next word: a held word's MSB appears in the cycle after the last gap bit. With GAP=0, it appears in the cycle after the previous LSB.
- `busy` is high in cycles k+1 .. k+WIDTH+GAP and stays high across back-to-back words.
- Steady-state throughput: one word per WIDTH+GAP cycles when the source keeps `din_valid` high.

## Test plan
- **Single word**: reset, then `din`=8'h81 with valid for one cycle (GAP=2).
  - `J` must read 1,0,0,0,0,0,0,1 in cycles 1..8, then 0,0.
  - `word_done` is high only in cycle 8.
  - `busy` is high in cycles 1..10 and low in cycle 11.
  - `din_ready` stays 1 throughout.
- **Back to back**: present 8'hA5 then 8'h3C with valid held high.
  - The second word is accepted at edge 1, and `din_ready`=0 in cycles 2..10.
  - `J` carries A5 bits, then 0,0, then 3C bits starting at cycle 11.
  - `word_done` pulses at cycles 8 and 18.
- **Backpressure**: keep valid high with three words queued.
  - The third word is accepted only one cycle after the hold-to-shifter transfer, at edge 11.
  - No word may be lost or duplicated.
- **GAP=0**: send 8'hFF then 8'h00 with valid held high.
  - `J` shows 8 ones followed immediately by 8 zeros, with no idle bit between them.
  - `busy` stays high through cycle 16.
- **Reset mid-frame**: assert `rst`=0 at edge 4 of an 8'hF0 frame while the hold is full.
  - From cycle 5: `J`=0, `busy`=0, and `word_done` never pulses.
  - `din_ready`=1, and the held word is never sent.
- **Integration with the detector** (GAP=0): send 8'h00, 8'h81 into the detector's `J`.
  - The detector's `Y` pulses exactly once, at a fixed latency after this block's `word_done` for 8'h81.
